// File: rtl/pc_fetch_unit.sv
// Program counter / next-address stage feeding the instruction memory address port.
// Optional retire counter enabled by defining PC_RETIRE_COUNT_EN.
module pc_fetch_unit #(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 181,
    parameter int RESET_PC  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_reg,
    input  logic [31:0]       reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              pc_valid,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       retire_count
);
    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_FAULT} state_t;

    // One extra bit so MEM_DEPTH == 2^ADDR_W is representable and never traps.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_next;
    logic              w_next_oor;
    logic              w_inc_oor;
    logic              w_unused_bits;

    assign w_unused_bits = &{1'b0, reg_target[31:ADDR_W]};
    assign w_pc_plus1    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        w_next = w_pc_plus1;
        if (jump_reg)          w_next = reg_target[ADDR_W-1:0];
        else if (jump)         w_next = jump_target;
        else if (branch_taken) w_next = branch_target;
    end

    assign w_next_oor = ({1'b0, w_next} >= LP_DEPTH);
    assign w_inc_oor  = ({1'b0, w_pc_plus1} >= LP_DEPTH);

    // On a trap the PC stays at the offending instruction, not the target.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc    <= ADDR_W'(RESET_PC);
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!stall) begin
                        if (halt)            r_state <= ST_HALTED;
                        else if (w_next_oor) r_state <= ST_FAULT;
                        else                 r_pc    <= w_next;
                    end
                end
                ST_HALTED: begin
                    if (resume && !stall) begin
                        if (w_inc_oor) begin
                            r_state <= ST_FAULT;
                        end else begin
                            r_pc    <= w_pc_plus1;
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_plus1 = w_pc_plus1;
    assign pc_valid = (r_state == ST_RUN);
    assign halted   = (r_state == ST_HALTED);
    assign fault    = (r_state == ST_FAULT);

`ifdef PC_RETIRE_COUNT_EN
    logic        w_advance;
    logic [31:0] r_retire;

    assign w_advance = ((r_state == ST_RUN) && !stall && !halt && !w_next_oor) ||
                       ((r_state == ST_HALTED) && resume && !stall && !w_inc_oor);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                             r_retire <= '0;
        else if (w_advance && r_retire != '1)  r_retire <= r_retire + 32'd1;
    end

    assign retire_count = r_retire;
`else
    assign retire_count = '0;
`endif

endmodule
